// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Thumb instruction fetch stage with a credit-limited prefetch
//               FIFO, in-flight response dropping on branch, and an IR register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] NOP_INSN = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_ir_r,
  output logic [31:0] o_pc_r,
  output logic        o_ir_valid_r
);

  localparam int unsigned       CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam logic [31:0]       BOOT_PC   = RESET_PC & ~32'd1;
  localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {S_BOOT = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [47:0]      mem_q [DEPTH];
  logic [47:0]      mem_d [DEPTH];

  logic             branch, advance, req, xfer, drop, push, pop;
  logic [CNT_W-1:0] out_next;
  logic [31:0]      target;

  always_comb begin
    branch   = (i_mode == 2'd2);
    advance  = (i_mode == 2'd1);
    target   = i_branch_target & ~32'd1;
    // Buffered words plus in-flight requests may never exceed the FIFO size.
    req      = (state_q == S_RUN) && !branch &&
               (({1'b0, count_q} + {1'b0, outstanding_q}) < CREDITS);
    xfer     = req && i_imem_gnt;
    drop     = i_imem_rvalid && (drop_cnt_q != '0);
    push     = i_imem_rvalid && !drop && !branch;
    pop      = advance && (count_q != '0);
    out_next = outstanding_q + CNT_W'(xfer) - CNT_W'(i_imem_rvalid);
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    outstanding_d = out_next;
    drop_cnt_d    = drop_cnt_q - CNT_W'(drop);
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_d         = mem_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      default: state_d = state_q;
    endcase

    if (branch) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = out_next;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ir_d       = NOP_INSN;
      ir_valid_d = 1'b0;
    end else begin
      if (xfer) fetch_pc_d = fetch_pc_q + 32'd2;
      if (push) begin
        mem_d[wr_ptr_q] = {resp_pc_q, i_imem_rdata};
        wr_ptr_d        = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        resp_pc_d       = resp_pc_q + 32'd2;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (advance) begin
        if (pop) begin
          ir_d       = mem_q[rd_ptr_q][15:0];
          pc_d       = mem_q[rd_ptr_q][47:16];
          ir_valid_d = 1'b1;
        end else begin
          ir_d       = NOP_INSN;
          ir_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= BOOT_PC;
      resp_pc_q     <= BOOT_PC;
      pc_q          <= '0;
      ir_q          <= NOP_INSN;
      ir_valid_q    <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_q         <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (count_q != FULL_CNT);
  end

  assign o_imem_req   = req;
  assign o_imem_addr  = fetch_pc_q;
  assign o_ir_r       = ir_q;
  assign o_pc_r       = pc_q;
  assign o_ir_valid_r = ir_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with an in-order
//               fixed-latency memory model returning rdata = addr[15:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hBF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [31:0] i_branch_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [15:0] i_imem_rdata;
  logic [15:0] o_ir_r;
  logic [31:0] o_pc_r;
  logic        o_ir_valid_r;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .NOP_INSN (16'hBF00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mode          (i_mode),
    .i_branch_target (i_branch_target),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_ir_r          (o_ir_r),
    .o_pc_r          (o_pc_r),
    .o_ir_valid_r    (o_ir_valid_r)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc      = 0;
  int          lat      = 1;
  int          checks   = 0;
  int          failures = 0;
  logic        last_req;
  logic [31:0] last_addr;
  logic [31:0] exp_pc;
  logic [15:0] hold_ir;
  logic [31:0] hold_pc;
  logic [31:0] hold_addr;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present due response, sample request pre-edge, advance past edge.
  task automatic tick();
    rsp_t r;
    if (rst) pend.delete();
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      r             = pend.pop_front();
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = r.data;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 16'h0;
    end
    #1;
    last_req  = o_imem_req;
    last_addr = o_imem_addr;
    if (!rst && o_imem_req === 1'b1 && i_imem_gnt === 1'b1)
      pend.push_back('{due: cyc + lat, data: o_imem_addr[15:0]});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_adv(input int n, input int minw);
    int words = 0;
    for (int i = 0; i < n; i++) begin
      i_mode = 2'd1;
      tick();
      if (o_ir_valid_r === 1'b1) begin
        chk("seq_ir", 48'(o_ir_r), 48'(exp_pc[15:0]));
        chk("seq_pc", 48'(o_pc_r), 48'(exp_pc));
        exp_pc = exp_pc + 32'd2;
        words++;
      end else begin
        chk("bubble_ir", 48'(o_ir_r), 48'(NOP));
      end
    end
    chk("min_words", 48'(words >= minw), 48'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_mode = 2'd0; i_branch_target = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 16'h0;
    tick(); tick();
    chk("rst_ir",    48'(o_ir_r),       48'(NOP));
    chk("rst_pc",    48'(o_pc_r),       48'(0));
    chk("rst_valid", 48'(o_ir_valid_r), 48'(0));
    chk("rst_req",   48'(o_imem_req),   48'(0));

    // Boot stream: three bubble edges, then word 0 valid on the fourth.
    rst = 1'b0; i_mode = 2'd1; i_imem_gnt = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("boot_valid", 48'(o_ir_valid_r), 48'(0));
      chk("boot_ir",    48'(o_ir_r),       48'(NOP));
    end
    tick();
    chk("first_valid", 48'(o_ir_valid_r), 48'(1));
    chk("first_ir",    48'(o_ir_r),       48'(16'h0000));
    chk("first_pc",    48'(o_pc_r),       48'(32'h0));
    exp_pc = 32'h2;
    run_adv(12, 6);

    // Stall until the FIFO fills; outputs must hold and requests stop.
    hold_ir = o_ir_r; hold_pc = o_pc_r;
    i_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stall_ir", 48'(o_ir_r), 48'(hold_ir));
      chk("stall_pc", 48'(o_pc_r), 48'(hold_pc));
      if (i >= 3) chk("stall_req", 48'(last_req), 48'(0));
    end
    chk("stall_full", 48'(dut.count_q), 48'(2));
    run_adv(10, 4);

    // Grant withheld: request and address stay put while IR bubbles.
    i_imem_gnt = 1'b0;
    run_adv(4, 0);
    hold_addr = o_imem_addr;
    chk("gnt_low_addr", 48'(hold_addr), 48'(exp_pc));
    for (int i = 0; i < 4; i++) begin
      i_mode = 2'd1;
      tick();
      chk("gnt_low_req",   48'(last_req),     48'(1));
      chk("gnt_low_hold",  48'(last_addr),    48'(hold_addr));
      chk("gnt_low_ir",    48'(o_ir_r),       48'(NOP));
      chk("gnt_low_valid", 48'(o_ir_valid_r), 48'(0));
    end
    i_imem_gnt = 1'b1;
    run_adv(10, 4);

    // Reset with buffered words, then restart from RESET_PC.
    i_mode = 2'd0;
    tick(); tick(); tick();
    chk("pre_rst_fifo", 48'(dut.count_q != '0), 48'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_ir",    48'(o_ir_r),       48'(NOP));
    chk("mid_rst_pc",    48'(o_pc_r),       48'(0));
    chk("mid_rst_valid", 48'(o_ir_valid_r), 48'(0));
    chk("mid_rst_req",   48'(o_imem_req),   48'(0));
    rst = 1'b0;
    exp_pc = 32'h0;
    run_adv(14, 6);

    // Branch to 0x101 with two requests in flight on a 3-cycle memory.
    rst = 1'b1; i_mode = 2'd0;
    tick();
    rst = 1'b0; lat = 3;
    tick(); tick(); tick();
    chk("br_inflight", 48'(dut.outstanding_q), 48'(2));
    i_mode = 2'd2; i_branch_target = 32'h0000_0101;
    tick();
    chk("br_req",   48'(last_req),       48'(0));
    chk("br_ir",    48'(o_ir_r),         48'(NOP));
    chk("br_valid", 48'(o_ir_valid_r),   48'(0));
    chk("br_drop",  48'(dut.drop_cnt_q), 48'(2));
    exp_pc = 32'h100;
    run_adv(24, 4);
    chk("br_drop_done", 48'(dut.drop_cnt_q), 48'(0));

    // Back-to-back branches: only the 0x300 stream may surface.
    i_mode = 2'd2; i_branch_target = 32'h200;
    tick();
    chk("bb1_ir", 48'(o_ir_r), 48'(NOP));
    i_branch_target = 32'h300;
    tick();
    chk("bb2_ir",    48'(o_ir_r),       48'(NOP));
    chk("bb2_valid", 48'(o_ir_valid_r), 48'(0));
    exp_pc = 32'h300;
    run_adv(24, 4);
    chk("bb_drop_done", 48'(dut.drop_cnt_q), 48'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
